// File: rtl/addsub_pipe.sv
// Pipelined adder/subtractor: carry chain split into STAGES chunks, one chunk per cycle, valid/ready on both sides.
// Latency STAGES cycles; in_ready = load[0], a combinational chain from out_ready. Optional saturation: ADDSUB_PIPE_SAT_EN.
module addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  input  logic             Cin,
  input  logic             sub,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Ofl,
  output logic             Cout,
  output logic             Zero
);

  localparam int CW = WIDTH / STAGES;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] src_v;

  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             sg_q  [STAGES];
  logic             sb_q  [STAGES];

  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic             src_c [STAGES];
  logic             src_sg[STAGES];
  logic             src_sb[STAGES];
  logic [CW:0]      csum  [STAGES];
  logic [WIDTH-1:0] nxt_s [STAGES];

  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] fout;
  logic             fcout;
  logic             am;
  logic             bm;
  logic             sovf;
  logic             uovf;
  logic             fofl;

  // A stage loads when it or any stage downstream of it can move.
  always_comb begin
    load = '0;
    load[STAGES-1] = out_ready | ~v_q[STAGES-1];
    for (int k = STAGES - 2; k >= 0; k--) begin
      load[k] = ~v_q[k] | load[k+1];
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v_q[STAGES-1];

  // Stage 0 is fed straight from the ports with B pre-inverted for subtraction.
  always_comb begin
    src_v[0]  = in_valid;
    src_a[0]  = InA;
    src_b[0]  = sub ? ~InB : InB;
    src_c[0]  = sub | Cin;
    src_s[0]  = '0;
    src_sg[0] = sign;
    src_sb[0] = sub;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k]  = v_q[k-1];
      src_a[k]  = a_q[k-1];
      src_b[k]  = b_q[k-1];
      src_c[k]  = c_q[k-1];
      src_s[k]  = s_q[k-1];
      src_sg[k] = sg_q[k-1];
      src_sb[k] = sb_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      csum[k] = {1'b0, src_a[k][k*CW +: CW]} + {1'b0, src_b[k][k*CW +: CW]}
              + {{CW{1'b0}}, src_c[k]};
      nxt_s[k] = src_s[k];
      nxt_s[k][k*CW +: CW] = csum[k][CW-1:0];
    end
  end

  // Flags (and optional saturation) resolve alongside the last chunk.
  always_comb begin
    res   = nxt_s[STAGES-1];
    fcout = csum[STAGES-1][CW];
    am    = src_a[STAGES-1][WIDTH-1];
    bm    = src_b[STAGES-1][WIDTH-1];
    sovf  = (am == bm) && (res[WIDTH-1] != am);
    uovf  = fcout ^ src_sb[STAGES-1];
    fofl  = src_sg[STAGES-1] ? sovf : uovf;
    fout  = res;
`ifdef ADDSUB_PIPE_SAT_EN
    if (fofl) begin
      if (src_sg[STAGES-1])
        fout = am ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else
        fout = src_sb[STAGES-1] ? '0 : '1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      Out  <= '0;
      Ofl  <= 1'b0;
      Cout <= 1'b0;
      Zero <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        s_q[k]  <= '0;
        c_q[k]  <= 1'b0;
        sg_q[k] <= 1'b0;
        sb_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) v_q[k] <= src_v[k];
        if (load[k] && src_v[k]) begin
          a_q[k]  <= src_a[k];
          b_q[k]  <= src_b[k];
          s_q[k]  <= nxt_s[k];
          c_q[k]  <= csum[k][CW];
          sg_q[k] <= src_sg[k];
          sb_q[k] <= src_sb[k];
        end
      end
      if (load[STAGES-1] && src_v[STAGES-1]) begin
        Out  <= fout;
        Ofl  <= fofl;
        Cout <= fcout;
        Zero <= ~|fout;
      end
    end
  end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined adder/subtractor. Next generation of the 16-bit single-cycle CLA add/sub used by the execute stage.
- The carry chain is split into STAGES equal chunks, with one chunk resolved per cycle. The carry and the remaining operand bits are registered between chunks.
- Valid/ready handshakes on both sides. Used by the multi-cycle ALU path and the address-generation unit, where timing closure needs a registered carry chain.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be divisible by STAGES.
- STAGES, 4, number of pipeline stages (1..8). Chunk width CW = WIDTH/STAGES.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand transaction present
- in_ready  output  1  block can accept a transaction this cycle
- InA  input  WIDTH  operand A
- InB  input  WIDTH  operand B
- Cin  input  1  carry-in for add (ignored when sub=1)
- sub  input  1  1 = A - B (B inverted, carry-in forced 1)
- sign  input  1  1 = signed overflow semantics, 0 = unsigned
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result this cycle
- Out  output  WIDTH  sum/difference
- Ofl  output  1  overflow per sign/sub
- Cout  output  1  raw carry out of MSB
- Zero  output  1  Out == 0

Behaviour:
- Reset (async assert, sync-safe deassert): all stage valid bits 0, out_valid=0, Out=0, Ofl=0, Cout=0, Zero=0.
- in_ready is 1 out of reset. In-flight transactions are discarded; nothing is emitted after reset releases.
- Acceptance occurs on a rising edge with in_valid & in_ready. At that edge the block captures:
  - Beff = sub ? ~InB : InB
  - c0 = sub ? 1 : Cin
  - sign, sub, and the MSBs of InA and Beff
- Stage k (0..STAGES-1) adds chunk k of A and Beff with the carry from stage k-1 and registers the partial sum, the carry, and the untouched upper chunks. The final stage register drives Out/Cout/Ofl/Zero directly.
- Latency: a transaction accepted at edge t gives out_valid=1 after edge t+STAGES-1, i.e. STAGES cycles. STAGES=1 is one registered cycle.
- Throughput: one transaction per cycle while out_ready=1.
- Advance rule: stage k loads when stage k is empty or stage k+1 loads (final stage: when out_ready=1 or out_valid=0).
- in_ready = ~valid[0] | load[1]. This is a combinational chain from out_ready; no bubble insertion.
- Back-pressure: while out_valid=1 and out_ready=0, Out/Ofl/Cout/Zero hold stable. Upstream stages fill, then in_ready drops.
- Ordering: strict FIFO. No loss or duplication.
- Flags, computed in the final stage:
  - Cout = carry out of bit WIDTH-1.
  - Signed overflow = (A[msb]==Beff[msb]) & (Out[msb]!=A[msb]).
  - Unsigned overflow = Cout ^ sub. For subtraction this is a borrow.
  - Ofl = sign ? signed overflow : unsigned overflow.
  - Zero = ~|Out.
- Simultaneous accept and emit in the same cycle is legal when the pipeline is full and out_ready=1.
- Arithmetic wraps modulo 2^WIDTH unless the optional feature below is compiled in.

Optional Feature:
- Macro ADDSUB_PIPE_SAT_EN.
- When defined, the final stage saturates on overflow:
  - signed overflow → Out = A[msb] ? 100..0 : 011..1
  - unsigned add overflow → all ones
  - unsigned sub borrow → all zeros
- Ofl still reports the overflow. Zero reflects the saturated value. Saturation adds no extra cycle.
- When undefined: wrap-around result, no saturation logic present.

Test Plan:
- WIDTH=16, STAGES=4, InA=0x7FFF, InB=0x0001, sub=0, Cin=0, sign=1, out_ready=1 → 4 cycles later: Out=0x8000, Ofl=1, Cout=0, Zero=0.
- InA=0xFFFF, InB=0x0001, sign=0, sub=0 → Out=0x0000, Ofl=1, Cout=1, Zero=1. Same operands with sign=1 → Ofl=0.
- InA=0x0003, InB=0x0005, sub=1: sign=0 → Out=0xFFFE, Ofl=1 (borrow), Cout=0; sign=1 → Ofl=0. InA=0x8000, InB=0x0001, sub=1, sign=1 → Out=0x7FFF, Ofl=1.
- Stream 10 back-to-back random transactions while toggling out_ready 1/0 every 3 cycles → results match the reference model in order. in_ready=0 only when all 4 stages are full and out_ready=0. Out is stable during stalls.
- Accept 3 transactions, assert rst_n=0 for 1 cycle mid-flight → out_valid=0 immediately and all outputs 0. After release, no stale result emerges. The next transaction completes with 4-cycle latency.
- With ADDSUB_PIPE_SAT_EN defined:
  - 0x7FFF+0x0001 signed → Out=0x7FFF, Ofl=1.
  - 0x0003-0x0005 unsigned → Out=0x0000, Ofl=1, Zero=1.
